// File: rtl/ex_muldiv_iterative_pkg.sv
// Shared types and decode helpers for the EX-stage multiply/divide unit.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package ex_muldiv_iterative_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_MFHI  = 4'd10,
    OP_MFLO  = 4'd11,
    OP_NONE  = 4'd12
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  // Ops that occupy the unit for more than one edge.
  function automatic logic mdu_is_multicycle(input mdu_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Two's-complement interpretation of the operands.
  function automatic logic mdu_is_signed(input mdu_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider on operand magnitudes with a combinational sign fixup on the result.
// Latency: one quotient bit per step pulse; result valid after WIDTH steps following load.
// Backpressure: none; the owner sequences load/step and samples the result when it is done.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic             neg_quo_q, neg_rem_q, div0_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;

  // Operand magnitudes at load, and the trial subtraction for the current step.
  always_comb begin
    a_neg  = is_signed & dividend[WIDTH-1];
    b_neg  = is_signed & divisor[WIDTH-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  // Iteration registers: quo_q shifts dividend bits out and quotient bits in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (load) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvs_q     <= b_mag;
      dvd_q     <= dividend;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div0_q    <= (divisor == '0);
    end else if (step) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fixup; divide-by-zero returns all-ones quotient and the raw dividend.
  always_comb begin
    quotient  = neg_quo_q ? -quo_q : quo_q;
    remainder = neg_rem_q ? -rem_q : rem_q;
    if (div0_q) begin
      quotient  = '1;
      remainder = dvd_q;
    end
  end

endmodule

// File: rtl/ex_muldiv_iterative.sv
// EX-stage multiply/divide unit owning HI/LO; MTHI/MTLO write directly, MFHI/MFLO read combinationally.
// Latency: commit MUL_LATENCY edges after accept for mul/acc ops, WIDTH+1 for divides; done pulses then.
// Backpressure: registered busy; starts are ignored while an op is in flight; flush cancels without commit.
module ex_muldiv_iterative
  import ex_muldiv_iterative_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4,
  parameter bit MADD_ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_LATENCY = WIDTH + 1;
  localparam int MAX_LAT     = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW          = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_LATENCY - 1);

  mdu_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  mdu_op_t            op_q;
  logic [2*WIDTH-1:0] prod_q, prod, ext1, ext2, hilo_nxt;
  logic               accept, mt_write, commit, div_step, sgn;
  logic [WIDTH-1:0]   div_quo, div_rem;

  // Next state, accept and commit decisions; flush beats both start and commit.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mt_write  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !busy && !flush) begin
          if (mdu_is_multicycle(op)) begin
            accept    = 1'b1;
            state_nxt = mdu_is_div(op) ? ST_DIV : ST_MUL;
          end else if (op == OP_MTHI || op == OP_MTLO) begin
            mt_write = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt == MUL_LAST) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DIV_LAST) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Full-width product at accept; sign/zero extension lets one multiplier serve both signednesses.
  always_comb begin
    sgn  = mdu_is_signed(op);
    ext1 = sgn ? {{WIDTH{operand1[WIDTH-1]}}, operand1} : {{WIDTH{1'b0}}, operand1};
    ext2 = sgn ? {{WIDTH{operand2[WIDTH-1]}}, operand2} : {{WIDTH{1'b0}}, operand2};
    prod = ext1 * ext2;
  end

  // Value written to {hi,lo} on commit; accumulate uses HI/LO as they stand at commit.
  always_comb begin
    hilo_nxt = prod_q;
    if (mdu_is_div(op_q)) begin
      hilo_nxt = {div_rem, div_quo};
    end else if (MADD_ENABLE && (op_q == OP_MADD || op_q == OP_MADDU)) begin
      hilo_nxt = {hi, lo} + prod_q;
    end else if (MADD_ENABLE && (op_q == OP_MSUB || op_q == OP_MSUBU)) begin
      hilo_nxt = {hi, lo} - prod_q;
    end
  end

  assign div_step = (state == ST_DIV) && (cnt != DIV_LAST);

  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept && mdu_is_div(op)),
    .step      (div_step),
    .is_signed (mdu_is_signed(op)),
    .dividend  (operand1),
    .divisor   (operand2),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Delay counter, busy/done flags, latched op/product and the architectural HI/LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_q   <= OP_NONE;
      prod_q <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      busy <= (state != ST_IDLE) && (state_nxt != ST_IDLE);
      done <= commit;
      cnt  <= (state != ST_IDLE && state_nxt != ST_IDLE) ? cnt + CW'(1) : '0;
      if (accept) begin
        op_q   <= op;
        prod_q <= prod;
      end
      if (commit) begin
        {hi, lo} <= hilo_nxt;
      end else if (mt_write) begin
        if (op == OP_MTHI) hi <= operand1;
        else               lo <= operand1;
      end
    end
  end

  // Move-from path is purely combinational on the current op.
  assign data_read = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : '0;

endmodule
